// File: rtl/nios2_sopc_nios2_0_cpu_ocimem_ctrl_pkg.sv
// Shared definitions for the debug OCI memory controller.
//   - CPU register-space offsets (low two address bits, address MSB = 1)
//   - jdo field positions used by the JTAG strobes
//   - read-return pipeline state type
package nios2_sopc_nios2_0_cpu_ocimem_ctrl_pkg;

  localparam int unsigned REG_MONDREG = 0;
  localparam int unsigned REG_MONAREG = 1;
  localparam int unsigned REG_STATUS  = 2;

  localparam int unsigned JDO_LOAD_ADDR = 35;
  localparam int unsigned JDO_CLR_FLAGS = 34;
  localparam int unsigned JDO_DATA_MSB  = 34;
  localparam int unsigned JDO_DATA_LSB  = 3;
  localparam int unsigned JDO_ADDR_LSB  = 3;

  // Who owns the RAM data coming back this cycle.
  typedef enum logic [1:0] {
    RET_IDLE = 2'd0,
    RET_JTAG = 2'd1,
    RET_CPU  = 2'd2
  } ret_e;

endpackage

// File: rtl/nios2_sopc_nios2_0_cpu_ocimem_ram.sv
// Single-port debug RAM, 32-bit words, per-byte write enables,
// registered read (data for i_addr appears one cycle later).
// Contents are not reset.
//   clk      : CPU clock
//   i_addr   : word address
//   i_we     : write enable (qualified per byte by i_be)
//   i_be     : byte enables
//   i_wdata  : write data
//   o_rdata  : read data, registered
module nios2_sopc_nios2_0_cpu_ocimem_ram #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_we && i_be[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/nios2_sopc_nios2_0_cpu_ocimem_ctrl.sv
// Debug OCI memory controller (CPU clock domain).
// Executes JTAG reads/writes into the debug RAM via the MonAReg/MonDReg
// pair and offers a CPU debug slave port onto the same RAM plus a small
// register space. JTAG always wins the single RAM port; a colliding CPU
// access is stalled with waitrequest for that cycle.
// Optional build macro: OCIMEM_ROM_PROTECT_EN -- when defined, CPU writes
// to RAM words 0..ROM_WORDS-1 are dropped (JTAG writes still allowed).
// Ports:
//   clk, reset_n              : clock, async active-low reset
//   jdo                       : JTAG command/data word
//   take_action_ocimem_a      : [35] load MonAReg, [34] clear ready/error
//   take_no_action_ocimem_a   : JTAG read at MonAReg, then increment
//   take_action_ocimem_b      : JTAG write jdo[34:3] at MonAReg, then increment
//   address/read/write/...    : CPU slave port (address MSB selects registers)
//   readdata, waitrequest     : CPU read data (1 cycle after accept), stall
//   MonDReg, monitor_ready/error : monitor state back to the JTAG wrapper
module nios2_sopc_nios2_0_cpu_ocimem_ctrl
  import nios2_sopc_nios2_0_cpu_ocimem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned ROM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W:0]   address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  logic [ADDR_W-1:0] r_mon_areg;
  logic [31:0]       r_mon_dreg;
  logic              r_ready;
  logic              r_error;
  logic [31:0]       r_reg_rdata;
  ret_e              r_ret;
  ret_e              w_ret_nxt;

  logic              w_strobe;
  logic              w_cpu_ok;
  logic              w_cpu_wr;
  logic              w_cpu_rd;
  logic              w_reg_sel;
  logic              w_in_rom;
  logic              w_rom_block;
  logic [31:0]       w_jdo_data;
  logic [ADDR_W-1:0] w_jdo_addr;
  logic [31:0]       w_reg_rdata;

  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [3:0]        w_ram_be;
  logic [31:0]       w_ram_wdata;
  logic [31:0]       w_ram_rdata;

  logic              w_unused;

  assign w_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_cpu_ok   = (read | write) & ~w_strobe;
  assign w_cpu_wr   = write & w_cpu_ok;
  assign w_cpu_rd   = read & w_cpu_ok;
  assign w_reg_sel  = address[ADDR_W];
  assign w_jdo_data = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
  assign w_jdo_addr = jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];

  assign waitrequest   = (read | write) & w_strobe;
  assign MonDReg       = r_mon_dreg;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

  assign w_in_rom = (32'(address[ADDR_W-1:0]) < ROM_WORDS);
`ifdef OCIMEM_ROM_PROTECT_EN
  assign w_rom_block = w_in_rom;
  assign w_unused    = ^{jdo[37:36], jdo[2:0]};
`else
  assign w_rom_block = 1'b0;
  assign w_unused    = ^{jdo[37:36], jdo[2:0], w_in_rom};
`endif

  // RAM port: a JTAG strobe owns the port; otherwise the CPU does.
  always_comb begin
    w_ram_addr  = r_mon_areg;
    w_ram_we    = 1'b0;
    w_ram_be    = '1;
    w_ram_wdata = w_jdo_data;
    if (take_action_ocimem_b) begin
      w_ram_we = 1'b1;
    end else if (!w_strobe) begin
      w_ram_addr  = address[ADDR_W-1:0];
      w_ram_we    = w_cpu_wr & ~w_reg_sel & debugaccess & ~w_rom_block;
      w_ram_be    = byteenable;
      w_ram_wdata = writedata;
    end
  end

  nios2_sopc_nios2_0_cpu_ocimem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_ret_nxt = RET_IDLE;
    if (take_no_action_ocimem_a) begin
      w_ret_nxt = RET_JTAG;
    end else if (w_cpu_rd && !w_reg_sel) begin
      w_ret_nxt = RET_CPU;
    end
  end

  always_comb begin
    w_reg_rdata = '0;
    case (address[1:0])
      2'(REG_MONDREG): w_reg_rdata = r_mon_dreg;
      2'(REG_MONAREG): w_reg_rdata = 32'(r_mon_areg);
      2'(REG_STATUS):  w_reg_rdata = {30'b0, r_error, r_ready};
      default:         w_reg_rdata = '0;
    endcase
  end

  // RAM reads come straight from the RAM output register on the return
  // cycle; register reads are captured at acceptance.
  assign readdata = (r_ret == RET_CPU) ? w_ram_rdata : r_reg_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ret <= RET_IDLE;
    end else begin
      r_ret <= w_ret_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mon_areg <= '0;
    end else if (take_action_ocimem_a && jdo[JDO_LOAD_ADDR]) begin
      r_mon_areg <= w_jdo_addr;
    end else if (take_no_action_ocimem_a || take_action_ocimem_b) begin
      r_mon_areg <= r_mon_areg + ADDR_W'(1);
    end
  end

  // JTAG read return takes precedence over a CPU MonDReg write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mon_dreg <= '0;
    end else if (r_ret == RET_JTAG) begin
      r_mon_dreg <= w_ram_rdata;
    end else if (w_cpu_wr && w_reg_sel && address[1:0] == 2'(REG_MONDREG)) begin
      r_mon_dreg <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else if (take_action_ocimem_a && jdo[JDO_CLR_FLAGS]) begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else if (w_cpu_wr && w_reg_sel && address[1:0] == 2'(REG_STATUS)) begin
      if (writedata[0]) r_ready <= 1'b1;
      if (writedata[1]) r_error <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reg_rdata <= '0;
    end else if (w_cpu_rd && w_reg_sel) begin
      r_reg_rdata <= w_reg_rdata;
    end
  end

endmodule

// File: tb/tb_nios2_sopc_nios2_0_cpu_ocimem_ctrl.sv
module tb_nios2_sopc_nios2_0_cpu_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [8:0]  address;
  logic        read, write, debugaccess;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata, MonDReg;
  logic        waitrequest, monitor_ready, monitor_error;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] m_mondreg = '0;
  logic [31:0] cpu_q[$];
  logic [31:0] jtag_q[$];

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        dbg;
    logic [31:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  nios2_sopc_nios2_0_cpu_ocimem_ctrl #(
    .ADDR_W(8),
    .ROM_WORDS(64)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_a(input logic ld, input logic clr, input logic [7:0] a);
    jdo = '0;
    jdo[35] = ld;
    jdo[34] = clr;
    jdo[10:3] = a;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_w(input logic [31:0] d);
    jdo = {3'b000, d, 3'b000};
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic pop_jtag(input string nm);
    logic [31:0] e;
    if (jtag_q.size() == 0) begin
      check({nm, "_empty"}, 32'd1, 32'd0);
    end else begin
      e = jtag_q.pop_front();
      check(nm, MonDReg, e);
      m_mondreg = e;
    end
  endtask

  task automatic jtag_r(input logic [31:0] exp, input string nm);
    jtag_q.push_back(exp);
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    check({nm, "_t1"}, MonDReg, m_mondreg);
    tick();
    pop_jtag(nm);
  endtask

  task automatic cpu_acc(input logic wr, input logic [8:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic dbg, input logic [31:0] exp,
                         input string nm);
    logic [31:0] e;
    address = a; writedata = d; byteenable = be; debugaccess = dbg;
    write = wr; read = !wr;
    if (!wr) cpu_q.push_back(exp);
    #3;
    check({nm, "_wait"}, 32'(waitrequest), 32'd0);
    tick();
    read = 1'b0; write = 1'b0;
    if (wr && a == 9'h100) m_mondreg = d;
    if (!wr) begin
      if (cpu_q.size() == 0) begin
        check({nm, "_empty"}, 32'd1, 32'd0);
      end else begin
        e = cpu_q.pop_front();
        check(nm, readdata, e);
      end
    end
  endtask

  vec_t vecs[12];
  logic [31:0] exp_a5, exp_a3;

  initial begin
    reset_n = 1'b1; jdo = '0;
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    address = '0; read = 0; write = 0; writedata = '0; byteenable = '0; debugaccess = 0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_flags", {30'b0, monitor_error, monitor_ready}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_wait", 32'(waitrequest), 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    tick();

    // CPU table: RAM words >= 64 so results hold with or without ROM protect.
    vecs[0]  = '{1'b0, 9'h101, 32'h0,        4'hF, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 9'h102, 32'h0,        4'hF, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 9'h040, 32'h11223344, 4'hF, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 9'h040, 32'h0,        4'hF, 1'b1, 32'h11223344};
    vecs[4]  = '{1'b1, 9'h040, 32'hAABBCCDD, 4'h5, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 9'h040, 32'h0,        4'hF, 1'b1, 32'h11BB33DD};
    vecs[6]  = '{1'b1, 9'h040, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 9'h040, 32'h0,        4'hF, 1'b1, 32'h11BB33DD};
    vecs[8]  = '{1'b1, 9'h103, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 9'h103, 32'h0,        4'hF, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 9'h100, 32'h0BADF00D, 4'hF, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 9'h100, 32'h0,        4'hF, 1'b1, 32'h0BADF00D};
    for (int i = 0; i < 12; i++) begin
      cpu_acc(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].dbg,
              vecs[i].exp, $sformatf("vec%0d", i));
    end
    check("vec_mondreg_out", MonDReg, m_mondreg);

    // JTAG load / write / read with auto-increment
    jtag_a(1'b1, 1'b0, 8'h10);
    jtag_w(32'hDEADBEEF);
    jtag_w(32'h12345678);
    jtag_a(1'b1, 1'b0, 8'h10);
    jtag_r(32'hDEADBEEF, "jrd0");
    jtag_r(32'h12345678, "jrd1");
    cpu_acc(1'b0, 9'h101, '0, 4'hF, 1'b1, 32'h12, "areg_12");

    // Address wrap
    jtag_a(1'b1, 1'b0, 8'hFF);
    jtag_w(32'hA5A5A5A5);
    cpu_acc(1'b0, 9'h101, '0, 4'hF, 1'b1, 32'h0, "wrap_w");
    jtag_a(1'b1, 1'b0, 8'hFF);
    jtag_r(32'hA5A5A5A5, "wrap_rd");
    cpu_acc(1'b0, 9'h101, '0, 4'hF, 1'b1, 32'h0, "wrap_r");

    // Collision: CPU RAM write vs JTAG read
    jtag_a(1'b1, 1'b0, 8'h03);
    jtag_w(32'h0);
    jtag_a(1'b1, 1'b0, 8'h10);
    address = 9'h003; writedata = 32'h55; byteenable = 4'hF; debugaccess = 1'b1;
    write = 1'b1; jdo = '0; take_no_action_ocimem_a = 1'b1;
    jtag_q.push_back(32'hDEADBEEF);
    #3 check("col_wait1", 32'(waitrequest), 32'd1);
    tick();
    take_no_action_ocimem_a = 1'b0;
    #3 check("col_wait2", 32'(waitrequest), 32'd0);
    check("col_t1", MonDReg, m_mondreg);
    tick();
    write = 1'b0;
    pop_jtag("col_jrd");
`ifdef OCIMEM_ROM_PROTECT_EN
    exp_a3 = 32'h0;
`else
    exp_a3 = 32'h55;
`endif
    cpu_acc(1'b0, 9'h003, '0, 4'hF, 1'b1, exp_a3, "col_ram3");

    // JTAG read return beats a CPU MonDReg write in the same cycle
    jtag_a(1'b1, 1'b0, 8'h11);
    address = 9'h100; writedata = 32'hCAFEF00D; write = 1'b1;
    jdo = '0; take_no_action_ocimem_a = 1'b1;
    jtag_q.push_back(32'h12345678);
    #3 check("dreg_wait1", 32'(waitrequest), 32'd1);
    tick();
    take_no_action_ocimem_a = 1'b0;
    #3 check("dreg_wait2", 32'(waitrequest), 32'd0);
    tick();
    write = 1'b0;
    pop_jtag("dreg_conflict");
    cpu_acc(1'b0, 9'h100, '0, 4'hF, 1'b1, 32'h12345678, "dreg_rd");

    // Status flags
    cpu_acc(1'b1, 9'h102, 32'h3, 4'hF, 1'b1, '0, "st_set");
    check("st_flags_set", {30'b0, monitor_error, monitor_ready}, 32'h3);
    cpu_acc(1'b1, 9'h102, 32'h0, 4'hF, 1'b1, '0, "st_zero");
    cpu_acc(1'b0, 9'h102, '0, 4'hF, 1'b1, 32'h3, "st_rd");
    jdo = '0; jdo[34] = 1'b1; take_action_ocimem_a = 1'b1;
    #3 check("st_before_clr", {30'b0, monitor_error, monitor_ready}, 32'h3);
    tick();
    take_action_ocimem_a = 1'b0;
    check("st_cleared", {30'b0, monitor_error, monitor_ready}, 32'h0);
    cpu_acc(1'b0, 9'h101, '0, 4'hF, 1'b1, 32'h12, "clr_keeps_areg");

    // ROM protection (expectation depends on build)
`ifdef OCIMEM_ROM_PROTECT_EN
    exp_a5 = 32'h2;
`else
    exp_a5 = 32'h1;
`endif
    jtag_a(1'b1, 1'b0, 8'h05);
    jtag_w(32'h2);
    cpu_acc(1'b1, 9'h005, 32'h1, 4'hF, 1'b1, '0, "rom_cpu_w");
    cpu_acc(1'b0, 9'h005, '0, 4'hF, 1'b1, exp_a5, "rom_cpu_r");
    jtag_a(1'b1, 1'b0, 8'h05);
    jtag_r(exp_a5, "rom_jtag_r");
    jtag_a(1'b1, 1'b0, 8'h05);
    jtag_w(32'h2);
    cpu_acc(1'b0, 9'h005, '0, 4'hF, 1'b1, 32'h2, "rom_jtag_w");

    // Reset mid-stream
    cpu_acc(1'b1, 9'h102, 32'h3, 4'hF, 1'b1, '0, "pre_rst_st");
    jtag_a(1'b1, 1'b0, 8'h60);
    jdo = {3'b000, 32'h77777777, 3'b000};
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mrst_mondreg", MonDReg, 32'd0);
    check("mrst_flags", {30'b0, monitor_error, monitor_ready}, 32'd0);
    check("mrst_readdata", readdata, 32'd0);
    check("mrst_wait", 32'(waitrequest), 32'd0);
    tick();
    reset_n = 1'b1;
    m_mondreg = '0;
    tick();
    cpu_acc(1'b0, 9'h101, '0, 4'hF, 1'b1, 32'h0, "mrst_areg");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nios2_sopc_nios2_0_cpu_ocimem_ctrl.md
Name: nios2_sopc_nios2_0_cpu_ocimem_ctrl

Overview:
Debug on-chip memory (OCI memory) controller in the CPU clock domain, directly downstream of the debug-slave JTAG wrapper. It consumes jdo and the take_action_ocimem_*/take_no_action_ocimem_a strobes and executes JTAG reads and writes into the debug RAM. It returns MonDReg, monitor_ready and monitor_error to the wrapper. It also exposes a CPU-side debug slave port so monitor code can access the same RAM and status registers; JTAG has priority.

Parameters:
ADDR_W, 8, word-address width of debug RAM (depth 2**ADDR_W, 32-bit words)
ROM_WORDS, 64, words at the bottom of RAM treated as monitor ROM (used only by the optional feature)

Ports:
clk  in  1  CPU clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data/command word, stable while any strobe is high
take_action_ocimem_a  in  1  command strobe: jdo[35]=load address, jdo[34]=clear ready/error
take_no_action_ocimem_a  in  1  JTAG read strobe at MonAReg, then increment
take_action_ocimem_b  in  1  JTAG write strobe of jdo[34:3] to MonAReg, then increment
address  in  ADDR_W+1  CPU word address; MSB=1 selects register space
read  in  1  CPU read request
write  in  1  CPU write request
writedata  in  32  CPU write data
byteenable  in  4  CPU byte enables (RAM writes only)
debugaccess  in  1  CPU write qualifier for RAM
readdata  out  32  CPU read data, valid 1 cycle after acceptance
waitrequest  out  1  CPU stall
MonDReg  out  32  monitor data register to wrapper
monitor_ready  out  1  monitor ready flag
monitor_error  out  1  monitor error flag

Behaviour:
- Reset (async, reset_n low): MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, readdata=0, internal pipeline flags cleared. waitrequest is combinational and 0 while no strobe is present. RAM contents are not reset.
- Strobes are one-cycle pulses and mutually exclusive; at most one is high per cycle.
- ocimem_a with jdo[35]=1: MonAReg <= jdo[ADDR_W+2:3] at the next edge.
- ocimem_a with jdo[34]=1: monitor_ready and monitor_error <= 0.
- If both bits are set, both actions happen in the same cycle.
- JTAG read (no_action_a at cycle T):
  - RAM read issued at T using the current MonAReg.
  - MonAReg = MonAReg+1 after edge T.
  - RAM data returns at T+1; MonDReg is loaded at edge T+1, so it is visible at T+2.
- JTAG write (action_b at T): RAM[MonAReg] <= jdo[34:3] with all bytes enabled; MonAReg increments after edge T. MonDReg is unchanged.
- MonAReg increments modulo 2**ADDR_W (max value wraps to 0).
- Arbitration: waitrequest = (read|write) & (any ocimem strobe). A CPU access colliding with a strobe is held off for that cycle and accepted the next cycle. JTAG is never delayed.
- CPU RAM access (address MSB=0):
  - Write occurs only if debugaccess=1; otherwise it is silently dropped but still accepted.
  - Read data appears on readdata the cycle after acceptance.
- CPU register space (address MSB=1, low 2 bits):
  - 0 = MonDReg: read/write. A CPU write loads MonDReg at the next edge.
  - 1 = MonAReg: read-only, zero-extended.
  - 2 = status: reads {30'b0, monitor_error, monitor_ready}. Writing bit0=1 sets ready and bit1=1 sets error; writing 0 has no effect.
  - 3 = reads 0, writes ignored.
- Same-cycle conflicts:
  - A JTAG read returning data to MonDReg at T+1 and an accepted CPU MonDReg write at T+1: the JTAG data wins.
  - A JTAG clear (jdo[34]) and a CPU status set in the same cycle cannot collide, because arbitration stalls the CPU access.
- No FSM beyond a 1-deep read-return pipeline: idle / jtag_rd_ret / cpu_rd_ret flags, at most one set per cycle.

Optional Feature:
OCIMEM_ROM_PROTECT_EN
- Defined: CPU writes to RAM words 0..ROM_WORDS-1 are dropped even with debugaccess=1. JTAG writes remain allowed.
- Undefined: the whole RAM is CPU-writable with debugaccess=1; ROM_WORDS is unused.

Decomposition:
- Shared package holds:
  - register offsets (REG_MONDREG=0, REG_MONAREG=1, REG_STATUS=2)
  - jdo field indices (JDO_LOAD_ADDR=35, JDO_CLR_FLAGS=34, JDO_DATA_MSB=34, JDO_DATA_LSB=3, JDO_ADDR_LSB=3)
- One sub-module, nios2_sopc_nios2_0_cpu_ocimem_ram: single-port 32-bit RAM with byte enables and 1-cycle registered read.

Test Plan:
1. Reset mid-stream:
   - Stimulus: pulse ocimem_b, then assert reset_n=0 for 1 cycle.
   - Required: all outputs 0 immediately (async) and MonAReg=0.
2. JTAG load/write/read with auto-increment:
   - Stimulus: ocimem_a jdo[35]=1 addr=0x10; write 0xDEADBEEF, write 0x12345678; reload 0x10; read twice.
   - Required: MonDReg=0xDEADBEEF at T+2, then 0x12345678; MonAReg=0x12.
3. Address wrap:
   - Stimulus: load 0xFF, write 0xA5A5A5A5; load 0xFF, read.
   - Required: CPU read of MonAReg returns 0x000.
4. Collision:
   - Stimulus: CPU write 0x55 to RAM addr 3 (debugaccess=1) in the same cycle as no_action_a.
   - Required: waitrequest=1 for exactly 1 cycle; CPU write completes the next cycle; JTAG read unaffected.
5. Status flags:
   - Stimulus: CPU writes status=0x3, then ocimem_a jdo[34]=1.
   - Required: ready=error=1, then both 0 the cycle after the strobe.
   - Also: CPU write with debugaccess=0 leaves RAM unchanged.
6. OCIMEM_ROM_PROTECT_EN defined:
   - Stimulus: CPU write 0x1 to addr 5 with debugaccess=1; JTAG write 0x2 to addr 5.
   - Required: readback returns 0x2, and addr 5 is never 0x1.
